// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle control unit for the RV64-subset datapath
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// PC/IR/register-bank/memory strobes, the four datapath mux selects and the
// ALU operation code. Outputs are decoded from the registered state and the
// IR fields, so they fall to zero as soon as the asynchronous reset asserts.
//
// Optional feature: define RETIRE_COUNT_EN to add the retired-instruction
// counter and its retired_o port.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      leave IDLE and begin fetching
//   stop_i       return to IDLE at the next retire cycle
//   opcode_i     IR[6:0]
//   funct3_i     IR[14:12]
//   funct7_i     IR[30]
//   alu_flag_i   ALU branch-condition flag
//   pc_we_o      PC load enable (one pulse per retired instruction)
//   ir_we_o      IR load enable
//   rf_we_o      register bank write enable
//   mem_we_o     data memory write strobe
//   sel_mux1_o   ALU B: 0=imm, 1=doutB
//   sel_mux2_o   writeback: 00=mem, 01=ALU, 10=PC+4, 11=PC+imm
//   sel_mux3_o   next PC: 0=PC+4, 1=PC+imm
//   sel_mux4_o   ALU A: 0=PC, 1=doutA
//   alu_ctrl_o   ALU operation code
//   busy_o       high in any state except IDLE/HALT
//   illegal_o    high in HALT
//   retired_o    retired-instruction count (RETIRE_COUNT_EN only)
module multicycle_control_fsm #(
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110,
    parameter int         CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_i,
    input  logic             alu_flag_i,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             rf_we_o,
    output logic             mem_we_o,
    output logic             sel_mux1_o,
    output logic [1:0]       sel_mux2_o,
    output logic             sel_mux3_o,
    output logic             sel_mux4_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             busy_o,
    output logic             illegal_o
`ifdef RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0] retired_o
`endif
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;
    logic   is_load, is_store, is_r, is_addi, is_br, is_jal, is_legal;
    logic   use_sub;
    logic   [3:0] alu_op;

    assign is_load  = opcode_i == OP_LOAD;
    assign is_store = opcode_i == OP_STORE;
    assign is_r     = opcode_i == OP_RTYPE;
    assign is_addi  = opcode_i == OP_ADDI;
    assign is_br    = opcode_i == OP_BRANCH;
    assign is_jal   = opcode_i == OP_JAL;
    assign is_legal = is_load | is_store | is_r | is_addi | is_br | is_jal;
    assign use_sub  = (is_r & funct7_i & (funct3_i == 3'b000)) | is_br;
    assign alu_op   = use_sub ? ALU_SUB : ALU_ADD;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_we_o    = 1'b0;
        ir_we_o    = 1'b0;
        rf_we_o    = 1'b0;
        mem_we_o   = 1'b0;
        sel_mux1_o = 1'b0;
        sel_mux2_o = 2'b00;
        sel_mux3_o = 1'b0;
        sel_mux4_o = 1'b0;
        alu_ctrl_o = 4'b0000;
        case (state_q)
            S_IDLE:   state_d = start_i ? S_FETCH : S_IDLE;
            S_FETCH: begin
                ir_we_o = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                sel_mux4_o = 1'b1;
                sel_mux1_o = is_r | is_br;
                alu_ctrl_o = alu_op;
                if (is_br) begin
                    // Branch resolves and retires here; the flag picks the target.
                    pc_we_o    = 1'b1;
                    sel_mux3_o = alu_flag_i;
                    state_d    = stop_i ? S_IDLE : S_FETCH;
                end else begin
                    state_d = (is_load | is_store) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                // Keep the address computation stable while memory is accessed.
                sel_mux4_o = 1'b1;
                alu_ctrl_o = ALU_ADD;
                if (is_store) begin
                    mem_we_o = 1'b1;
                    pc_we_o  = 1'b1;
                    state_d  = stop_i ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we_o    = 1'b1;
                pc_we_o    = 1'b1;
                sel_mux2_o = is_load ? 2'b00 : is_jal ? 2'b10 : 2'b01;
                sel_mux3_o = is_jal;
                // Hold the ALU on the written result (or load address) through writeback.
                sel_mux4_o = ~is_jal;
                sel_mux1_o = is_r;
                alu_ctrl_o = is_jal ? 4'b0000 : alu_op;
                state_d    = stop_i ? S_IDLE : S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal_o = state_q == S_HALT;

`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      retired_q <= '0;
        else if (pc_we_o) retired_q <= retired_q + 1'b1;
    end

    assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    localparam int CW = 4;

    logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, stop_i = 1'b0;
    logic [6:0] opcode_i = 7'd0;
    logic [2:0] funct3_i = 3'd0;
    logic funct7_i = 1'b0, alu_flag_i = 1'b0;
    logic pc_we_o, ir_we_o, rf_we_o, mem_we_o, sel_mux1_o, sel_mux3_o, sel_mux4_o, busy_o, illegal_o;
    logic [1:0] sel_mux2_o;
    logic [3:0] alu_ctrl_o;
`ifdef RETIRE_COUNT_EN
    logic [CW-1:0] retired_o;
`endif

    multicycle_control_fsm #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .alu_flag_i(alu_flag_i),
        .pc_we_o(pc_we_o), .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .mem_we_o(mem_we_o),
        .sel_mux1_o(sel_mux1_o), .sel_mux2_o(sel_mux2_o), .sel_mux3_o(sel_mux3_o),
        .sel_mux4_o(sel_mux4_o), .alu_ctrl_o(alu_ctrl_o), .busy_o(busy_o), .illegal_o(illegal_o)
`ifdef RETIRE_COUNT_EN
        , .retired_o(retired_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;
    int ret_model = 0;

    wire [5:0]  strb = {pc_we_o, ir_we_o, rf_we_o, mem_we_o, busy_o, illegal_o};
    wire [14:0] all_out = {strb, alu_ctrl_o, sel_mux1_o, sel_mux2_o, sel_mux3_o, sel_mux4_o};

    logic [5:0] o_strb [8];
    logic [3:0] o_alu  [8];
    logic [1:0] o_m2   [8];
    logic       o_m1   [8];
    logic       o_m3   [8];
    logic       o_m4   [8];

    // Instruction classes: 0 load, 1 store, 2 R-type, 3 addi, 4 branch, 5 JAL
    function automatic logic [6:0] opc(input int c);
        case (c)
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] o);
        for (int i = 0; i < 6; i++) if (o == opc(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lat(input int c);
        return c == 4 ? 3 : c == 0 ? 5 : 4;
    endfunction

    function automatic logic [5:0] exp_strb(input int c, input int k);
        bit last = k == lat(c) - 1;
        return {last, k == 0, last && c != 1 && c != 4, last && c == 1, k < lat(c), 1'b0};
    endfunction

    function automatic logic [3:0] exp_alu(input int c, input logic f7, input logic [2:0] f3);
        return ((c == 2 && f7 && f3 == 3'b000) || c == 4) ? 4'b0110 : 4'b0010;
    endfunction

    function automatic logic exp_m3(input int c, input logic fl);
        return c == 4 ? fl : c == 5;
    endfunction

    function automatic logic [1:0] exp_m2(input int c);
        return c == 0 ? 2'b00 : c == 5 ? 2'b10 : 2'b01;
    endfunction

    // Lets the pending edge happen (entering FETCH), then presents the new IR
    // fields and records every cycle of the instruction at the falling edge.
    task automatic run_instr(input int c, input logic f7, input logic [2:0] f3, input logic fl, input logic stp);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        opcode_i = opc(c);
        funct7_i = f7;
        funct3_i = f3;
        alu_flag_i = fl;
        stop_i = stp;
        for (int k = 0; k < lat(c); k++) begin
            @(negedge clk_i);
            o_strb[k] = strb;
            o_alu[k] = alu_ctrl_o;
            o_m1[k] = sel_mux1_o;
            o_m2[k] = sel_mux2_o;
            o_m3[k] = sel_mux3_o;
            o_m4[k] = sel_mux4_o;
        end
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        stop_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        ret_model = 0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if (all_out !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (strb !== 6'd0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: strobes %b expected 000000", i, strb);
            end
        end
`ifdef RETIRE_COUNT_EN
        checks++;
        if (retired_o !== '0) begin
            failures++;
            $display("FAIL reset_retired: got %0d expected 0", retired_o);
        end
`endif
    endtask

    task automatic test_single_instrs();
        int c, r;
        logic f7, fl;
        logic [2:0] f3;
        for (int n = 0; n < 24; n++) begin
            c = n % 6;
            f7 = 1'($urandom);
            f3 = 3'($urandom);
            fl = 1'($urandom);
            if (n == 2) begin f7 = 1'b0; f3 = 3'b000; end
            if (n == 8) begin f7 = 1'b1; f3 = 3'b000; end
            start_i = 1'b1;
            run_instr(c, f7, f3, fl, 1'b1);
            ret_model++;
            r = lat(c) - 1;
            for (int k = 0; k <= r; k++) begin
                checks++;
                if (o_strb[k] !== exp_strb(c, k)) begin
                    failures++;
                    $display("FAIL single_strobes class %0d cycle %0d: got %b expected %b", c, k, o_strb[k], exp_strb(c, k));
                end
            end
            checks++;
            if ({o_alu[2], o_m1[2], o_m4[2]} !== {exp_alu(c, f7, f3), c == 2 || c == 4, 1'b1}) begin
                failures++;
                $display("FAIL single_exec_alu class %0d: alu/m1/m4 %b %b %b expected %b %b 1", c,
                         o_alu[2], o_m1[2], o_m4[2], exp_alu(c, f7, f3), c == 2 || c == 4);
            end
            if (c == 0) begin
                checks++;
                if ({o_alu[3], o_m1[3], o_m4[3]} !== {4'b0010, 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL load_mem_alu: alu/m1/m4 %b %b %b expected 0010 0 1", o_alu[3], o_m1[3], o_m4[3]);
                end
            end
            checks++;
            if (o_m3[r] !== exp_m3(c, fl)) begin
                failures++;
                $display("FAIL single_mux3 class %0d: got %b expected %b", c, o_m3[r], exp_m3(c, fl));
            end
            if (c != 1 && c != 4) begin
                checks++;
                if (o_m2[r] !== exp_m2(c)) begin
                    failures++;
                    $display("FAIL single_mux2 class %0d: got %b expected %b", c, o_m2[r], exp_m2(c));
                end
            end
            @(posedge clk_i);
            #1;
            checks++;
            if ({busy_o, illegal_o} !== 2'b00) begin
                failures++;
                $display("FAIL single_stop_idle class %0d: busy/illegal %b expected 00", c, {busy_o, illegal_o});
            end
        end
    endtask

    task automatic test_back_to_back();
        int cls [12];
        logic fl [12];
        int errs;
        for (int i = 0; i < 12; i++) begin
            cls[i] = int'($urandom_range(0, 5));
            fl[i] = 1'($urandom);
        end
        start_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_instr(cls[i], 1'($urandom), 3'($urandom), fl[i], i == 11);
            ret_model++;
            errs = 0;
            for (int k = 0; k < lat(cls[i]); k++) if (o_strb[k] !== exp_strb(cls[i], k)) errs++;
            checks++;
            if (errs != 0 || o_m3[lat(cls[i]) - 1] !== exp_m3(cls[i], fl[i])) begin
                failures++;
                $display("FAIL b2b_instr %0d class %0d: %0d strobe cycles wrong, mux3 %b expected %b",
                         i, cls[i], errs, o_m3[lat(cls[i]) - 1], exp_m3(cls[i], fl[i]));
            end
        end
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checks++;
        if ({busy_o, illegal_o} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_stop_wins: busy/illegal %b expected 00", {busy_o, illegal_o});
        end
`ifdef RETIRE_COUNT_EN
        checks++;
        if (retired_o !== CW'(ret_model)) begin
            failures++;
            $display("FAIL b2b_retired: got %0d expected %0d", retired_o, CW'(ret_model));
        end
`endif
    endtask

    task automatic test_illegal();
        logic [6:0] o;
        o = 7'h7F;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            if (t == 1) begin
                o = 7'($urandom);
                while (legal(o)) o = 7'($urandom);
            end
            start_i = 1'b1;
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            opcode_i = o;
            @(negedge clk_i);
            @(negedge clk_i);
            checks++;
            if (strb !== 6'b000010) begin
                failures++;
                $display("FAIL illegal_decode op %b: strobes %b expected 000010", o, strb);
            end
            for (int i = 0; i < 10; i++) begin
                @(posedge clk_i);
                #1;
                start_i = 1'($urandom);
                @(negedge clk_i);
                checks++;
                if (strb !== 6'b000001) begin
                    failures++;
                    $display("FAIL illegal_halt op %b cycle %0d: strobes %b expected 000001", o, i, strb);
                end
            end
            start_i = 1'b0;
        end
        do_reset();
        @(negedge clk_i);
        checks++;
        if (strb !== 6'd0) begin
            failures++;
            $display("FAIL illegal_reset_exit: strobes %b expected 000000", strb);
        end
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        opcode_i = opc(0);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({busy_o, alu_ctrl_o} !== {1'b1, 4'b0010}) begin
            failures++;
            $display("FAIL midreset_exec: busy/alu %b %b expected 1 0010", busy_o, alu_ctrl_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (all_out !== 15'd0) begin
            failures++;
            $display("FAIL midreset_async: outputs %h expected 0", all_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (all_out !== 15'd0) begin
                failures++;
                $display("FAIL midreset_hold cycle %0d: outputs %h expected 0", i, all_out);
            end
        end
        rst_ni = 1'b1;
        ret_model = 0;
        @(negedge clk_i);
        checks++;
        if (strb !== 6'd0) begin
            failures++;
            $display("FAIL midreset_idle: strobes %b expected 000000", strb);
        end
`ifdef RETIRE_COUNT_EN
        checks++;
        if (retired_o !== '0) begin
            failures++;
            $display("FAIL midreset_retired: got %0d expected 0", retired_o);
        end
`endif
    endtask

`ifdef RETIRE_COUNT_EN
    task automatic test_retire_wrap();
        do_reset();
        start_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run_instr(3, 1'($urandom), 3'($urandom), 1'b0, i == 16);
            ret_model++;
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (retired_o !== CW'(ret_model % (1 << CW))) begin
            failures++;
            $display("FAIL retire_wrap: got %0d expected %0d", retired_o, ret_model % (1 << CW));
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL retire_wrap_idle: busy %b expected 0", busy_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_instrs();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
`ifdef RETIRE_COUNT_EN
        test_retire_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
